led_seq_ctrl: RTL
=================

# led_seq_ctrl

Wishbone-configured LED pattern sequencer for the user project area: it drives the 8 LEDs on mprj_io[17:10] from an 8-entry pattern table, stepping at a programmable period. The 3 buttons on mprj_io[9:7] provide run/pause, single-step and rewind control. It sits between the Caravel Wishbone user bus and the button/LED IO pads and replaces direct firmware writes to the LED register.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode uses adr[31:8].
- DEBOUNCE_CYCLES, 16, stable cycles required to accept a button level (only with LED_SEQ_DEBOUNCE_EN).
- wb_clk_i  in  1  system clock, all logic on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle/strobe/write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- buttons  in  3  raw pad inputs, asynchronous to wb_clk_i.
- leds  out  8  LED drive, registered.
- leds_oeb  out  8  pad output-enable, active-low; constant 0 after reset release.

## Operation
- Registers (offset from BASE_ADDR):
  - 0x00 CTRL RW: [0] EN, [6:4] LEN-1 (1..8 active entries). Reset 0.
  - 0x04 PERIOD RW: [23:0] cycles per step; 0 treated as 1. Reset 0.
  - 0x08 STATUS RO: [2:0] index, [5:4] state (0 IDLE, 1 RUN, 2 PAUSE), [10:8] filtered button levels, [18:16] event flags.
  - 0x0C EVENTS W1C: [2:0] sticky press flags, one per button.
  - 0x20..0x3C PAT0..PAT7 RW: [7:0] pattern. Reset 0.
  - Unmapped offsets: reads return 0; writes ignored; still acked.
  - Byte enables are honoured per byte on all RW registers.
- Press = rising edge of a filtered button level. Each press sets its EVENTS flag. A W1C write in the same cycle as a set leaves the flag set.
- FSM:
  - IDLE: leds=0, index=0, timer=0. EN=1 -> RUN.
  - RUN: timer counts 0..PERIOD-1. At terminal count: index <= (index+1 == LEN) ? 0 : index+1, and timer <= 0. Button0 press -> PAUSE.
  - PAUSE: timer frozen. Button1 press advances index one step with the same wrap rule. Button0 press -> RUN, timer resumes from its held value.
  - Any state with EN=0 -> IDLE next cycle.
  - Button2 press in RUN/PAUSE: index=0, timer=0, state unchanged.
- Priority within a cycle: EN=0 > button2 > button1/terminal count > button0 state change.
- CTRL write that makes index >= new LEN: index=0 on the next cycle.
- leds = PAT[index], registered. A PAT write to the current index shows on leds one cycle after the ack.

## Timing
- Wishbone: ack is asserted the cycle after cyc&stb is sampled and lasts one cycle. Ack is low for at least one cycle between transfers. Register writes take effect on the ack edge.
- Button path: 2-flop synchronizer. With debounce, the level must be stable for DEBOUNCE_CYCLES. The press acts the cycle after the filtered edge.
- Step latency: leds update 1 cycle after the index changes.
- Reset, at any time: all registers 0, state IDLE, leds=0, wbs_ack_o=0, wbs_dat_o=0. A Wishbone transfer in flight at reset is dropped without ack.

## Configuration
- LED_SEQ_DEBOUNCE_EN defined: each synchronized button passes through a counter filter of DEBOUNCE_CYCLES.
- LED_SEQ_DEBOUNCE_EN undefined: the filtered level equals the synchronizer output, DEBOUNCE_CYCLES is unused, and press latency is 3 cycles.

## Structure
- Package led_seq_pkg holds:
  - register offset constants;
  - the state enum (IDLE/RUN/PAUSE);
  - field widths: PERIOD 24, index 3, LEN field 3.
- Sub-module button_debounce, instanced 3 times: synchronizer, optional filter and rising-edge pulse output.

## Test plan
- Reset, write PAT0..3=0x01,0x02,0x04,0x08, PERIOD=10, CTRL=0x31 -> leds step 01,02,04,08,01 every 10 cycles; STATUS[5:4]=1.
- In RUN, press button0 -> STATUS state=2 and leds hold for 100 cycles. Press button1 twice -> index advances by 2. Press button0 -> stepping resumes.
- Press button2 mid-sequence at index 3 -> index=0, leds=PAT0 next cycle; EVENTS=0x4. Write 0x4 to 0x0C -> EVENTS=0.
- Glitch button1 high for DEBOUNCE_CYCLES-2 cycles in PAUSE (debounce build) -> no step and no event flag. Without the macro, the same glitch steps once.
- CTRL LEN changed from 8 to 2 while index=5 -> index=0 next cycle, then wraps 0,1,0.
- Assert resetb low mid-RUN during a Wishbone read -> no ack, leds=0, and all registers read 0 after release.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED pattern sequencer.
package led_seq_pkg;

  localparam int PERIOD_W = 24;
  localparam int IDX_W    = 3;
  localparam int LEN_W    = 3;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PERIOD = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_EVENTS = 8'h0C;
  localparam logic [7:0] OFF_PAT0   = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // One step forward through the active part of the table, wrapping after LEN entries.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic [LEN_W-1:0] len_m1);
    return (idx == len_m1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: 2-flop synchronizer, optional stability filter
// (enabled by LED_SEQ_DEBOUNCE_EN) and a one-cycle rising-edge press pulse.
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic sync_p0, sync_p1, level_d;

  // Two-flop synchronizer for the asynchronous pad input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             filt;

  // Accept a new level only after it has differed from the filtered level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_p1 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      filt <= sync_p1;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync_p1;
`endif

  // Previous filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/led_seq_ctrl.sv
// Wishbone-configured 8-entry LED pattern sequencer with run/pause,
// single-step and rewind buttons. Define LED_SEQ_DEBOUNCE_EN to add the
// button stability filter.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [2:0]  buttons,
  output logic [7:0]  leds,
  output logic [7:0]  leds_oeb
);

  logic [2:0]          lvl, prs;
  logic                en;
  logic [LEN_W-1:0]    len_m1;
  logic [PERIOD_W-1:0] period, period_m1, timer;
  logic [7:0]          pat [8];
  logic [2:0]          events, ev_clr;
  state_t              state;
  logic [IDX_W-1:0]    index;
  logic                req, hit, wr;
  logic [7:0]          reg_off;
  logic                pat_hit;
  logic [31:0]         rdata;
  logic                unused_ok;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (wb_clk_i),
      .rst_n (resetb),
      .raw   (buttons[g]),
      .level (lvl[g]),
      .press (prs[g])
    );
  end

  assign leds_oeb  = 8'h00;
  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr        = req & wbs_we_i & hit;
  assign reg_off   = {wbs_adr_i[7:2], 2'b00};
  assign pat_hit   = (reg_off[7:5] == OFF_PAT0[7:5]);
  assign period_m1 = (period == '0) ? '0 : period - 1'b1;
  assign ev_clr    = (wr && reg_off == OFF_EVENTS && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

  // Read mux; unmapped offsets and foreign addresses read as zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      if (pat_hit) begin
        rdata = {24'h0, pat[reg_off[4:2]]};
      end else begin
        case (reg_off)
          OFF_CTRL:   rdata = {25'h0, len_m1, 3'b000, en};
          OFF_PERIOD: rdata = {8'h0, period};
          OFF_STATUS: rdata = {13'h0, events, 5'h0, lvl, 2'b00, state, 1'b0, index};
          OFF_EVENTS: rdata = {29'h0, events};
          default:    rdata = '0;
        endcase
      end
    end
  end

  // Single-cycle acknowledge with registered read data.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  // Configuration registers, byte-lane writes on the acknowledging edge.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      en     <= 1'b0;
      len_m1 <= '0;
      period <= '0;
      for (int i = 0; i < 8; i++) pat[i] <= '0;
    end else if (wr) begin
      if (reg_off == OFF_CTRL && wbs_sel_i[0]) begin
        en     <= wbs_dat_i[0];
        len_m1 <= wbs_dat_i[6:4];
      end
      if (reg_off == OFF_PERIOD) begin
        for (int b = 0; b < 3; b++)
          if (wbs_sel_i[b]) period[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
      end
      if (pat_hit && wbs_sel_i[0]) pat[reg_off[4:2]] <= wbs_dat_i[7:0];
    end
  end

  // Sticky press flags; a new press wins over a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) events <= '0;
    else         events <= (events & ~ev_clr) | prs;
  end

  // Sequencer FSM: EN off > rewind > out-of-range fixup > step > run/pause toggle.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      index <= '0;
      timer <= '0;
    end else if (!en) begin
      state <= ST_IDLE;
      index <= '0;
      timer <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (prs[2]) begin
            index <= '0;
            timer <= '0;
          end else if (index > len_m1) begin
            index <= '0;
          end else if (timer == period_m1) begin
            index <= next_index(index, len_m1);
            timer <= '0;
          end else if (prs[0]) begin
            state <= ST_PAUSE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (prs[2]) begin
            index <= '0;
            timer <= '0;
          end else if (index > len_m1) begin
            index <= '0;
          end else if (prs[1]) begin
            index <= next_index(index, len_m1);
          end else if (prs[0]) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          index <= '0;
          timer <= '0;
        end
      endcase
    end
  end

  // LED output register, one cycle behind the index.
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb)                leds <= '0;
    else if (state == ST_IDLE)  leds <= '0;
    else                        leds <= pat[index];
  end

endmodule
